// File: rtl/rattlesnake_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rattlesnake_mem_arbiter
//
// Shares the single memory-controller port of the Von Neumann core between
// the instruction fetch unit and the load/store unit. Single-cycle requests
// from either side are latched into a pending slot. While idle, one pending
// request at a time is issued to the memory controller, round-robin when
// both sides are waiting. The completion (read data plus word-address ack)
// is returned, registered, to the side that owns the access.
//
// Optional feature macro: RATTLESNAKE_MEM_ARB_WATCHDOG_EN
//   Defined     : an 8-bit watchdog runs while an access is outstanding. When
//                 TIMEOUT_CYCLES cycles pass after issue with no mem_done,
//                 bus_error pulses, the owner's done pulses with zero data
//                 and the arbiter returns to idle.
//   Not defined : no watchdog, bus_error is held 0 and an outstanding access
//                 waits for mem_done indefinitely.
//
// Ports
//   clk, reset_n      clock (posedge) and asynchronous active-low reset
//   sync_reset        synchronous clear of FSM, pending requests and outputs
//   fetch_read_en     fetch request pulse, fetch_read_addr captured with it
//   fetch_done        fetch completion pulse with fetch_data/fetch_addr_ack
//   data_read_en      load request pulse
//   data_write_en     store request pulse (wins if both strobes are high)
//   data_addr/_wdata  load/store byte address and store data
//   data_byte_en      store byte enables
//   data_done         load/store completion pulse with data_rdata
//   mem_enable        one-cycle command strobe with mem_write/_addr/_wdata/
//                     _byte_en (all zero while no command is issued)
//   mem_done          controller completion with mem_rdata/mem_addr_ack
//   bus_error         watchdog expiry pulse
// ---------------------------------------------------------------------------
module rattlesnake_mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int PC_BITWIDTH    = 32,
    parameter int MEM_ADDR_BITS  = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     fetch_read_en,
    input  logic [PC_BITWIDTH-1:0]   fetch_read_addr,
    output logic                     fetch_done,
    output logic [XLEN-1:0]          fetch_data,
    output logic [MEM_ADDR_BITS-1:0] fetch_addr_ack,
    input  logic                     data_read_en,
    input  logic                     data_write_en,
    input  logic [PC_BITWIDTH-1:0]   data_addr,
    input  logic [XLEN-1:0]          data_wdata,
    input  logic [3:0]               data_byte_en,
    output logic                     data_done,
    output logic [XLEN-1:0]          data_rdata,
    output logic                     mem_enable,
    output logic                     mem_write,
    output logic [PC_BITWIDTH-1:0]   mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [3:0]               mem_byte_en,
    input  logic                     mem_done,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic [MEM_ADDR_BITS-1:0] mem_addr_ack,
    output logic                     bus_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_FETCH = 3'b010,
        S_DATA  = 3'b100
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    // Pending request slots
    logic                     r_fetch_pend;
    logic [PC_BITWIDTH-1:0]   r_fetch_addr;
    logic                     r_data_pend;
    logic                     r_data_write;
    logic [PC_BITWIDTH-1:0]   r_data_addr;
    logic [XLEN-1:0]          r_data_wdata;
    logic [3:0]               r_data_be;
    logic                     r_last_grant_data;   // 1 = last grant went to DATA

    // Registered completion outputs
    logic                     r_fetch_done;
    logic [XLEN-1:0]          r_fetch_data;
    logic [MEM_ADDR_BITS-1:0] r_fetch_addr_ack;
    logic                     r_data_done;
    logic [XLEN-1:0]          r_data_rdata;

    logic                     w_grant_fetch;
    logic                     w_grant_data;
    logic                     w_finish;
    logic                     w_timeout;
    logic                     w_data_req;

    assign w_data_req = data_read_en | data_write_en;

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef RATTLESNAKE_MEM_ARB_WATCHDOG_EN
    // The counter holds the number of cycles elapsed since issue, so the
    // expiry is decided in the cycle that precedes the TIMEOUT_CYCLES-th one
    // and the registered done/bus_error land exactly TIMEOUT_CYCLES after issue.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wd_cnt;
    logic       r_bus_error;

    assign w_timeout = (r_state != S_IDLE) && !mem_done && (r_wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt    <= 8'd0;
            r_bus_error <= 1'b0;
        end else if (sync_reset) begin
            r_wd_cnt    <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_timeout;
            if (w_grant_fetch || w_grant_data) begin
                r_wd_cnt <= 8'd1;
            end else if (r_state != S_IDLE) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end else begin
                r_wd_cnt <= 8'd0;
            end
        end
    end

    assign bus_error = r_bus_error;
`else
    assign w_timeout = 1'b0;
    // TIMEOUT_CYCLES is never negative, so this is a constant 0.
    assign bus_error = (TIMEOUT_CYCLES < 0);
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Fetch wins unless data is also waiting and fetch had the last turn.
                if (r_fetch_pend && (!r_data_pend || r_last_grant_data)) begin
                    w_grant_fetch = 1'b1;
                    w_state_next  = S_FETCH;
                end else if (r_data_pend) begin
                    w_grant_data = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_done || w_timeout) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A clear in this cycle must not leak a command to the controller.
        if (sync_reset) begin
            w_grant_fetch = 1'b0;
            w_grant_data  = 1'b0;
            w_finish      = 1'b0;
            w_state_next  = S_IDLE;
        end
    end

    // Command bus: driven only during the grant cycle, zero otherwise.
    always_comb begin
        mem_enable  = w_grant_fetch | w_grant_data;
        mem_write   = w_grant_data & r_data_write;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = 4'h0;
        if (w_grant_fetch) begin
            mem_addr    = r_fetch_addr;
            mem_byte_en = 4'hF;
        end else if (w_grant_data) begin
            mem_addr    = r_data_addr;
            mem_wdata   = r_data_wdata;
            mem_byte_en = r_data_be;
        end
    end

    // -----------------------------------------------------------------------
    // Request capture, round-robin history and completion registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pend      <= 1'b0;
            r_fetch_addr      <= '0;
            r_data_pend       <= 1'b0;
            r_data_write      <= 1'b0;
            r_data_addr       <= '0;
            r_data_wdata      <= '0;
            r_data_be         <= 4'h0;
            r_last_grant_data <= 1'b1;
            r_fetch_done      <= 1'b0;
            r_fetch_data      <= '0;
            r_fetch_addr_ack  <= '0;
            r_data_done       <= 1'b0;
            r_data_rdata      <= '0;
        end else if (sync_reset) begin
            r_fetch_pend      <= 1'b0;
            r_fetch_addr      <= '0;
            r_data_pend       <= 1'b0;
            r_data_write      <= 1'b0;
            r_data_addr       <= '0;
            r_data_wdata      <= '0;
            r_data_be         <= 4'h0;
            r_last_grant_data <= 1'b1;
            r_fetch_done      <= 1'b0;
            r_fetch_data      <= '0;
            r_fetch_addr_ack  <= '0;
            r_data_done       <= 1'b0;
            r_data_rdata      <= '0;
        end else begin
            // A new pulse always refreshes the slot; a pulse in the grant
            // cycle therefore survives as the next pending request.
            if (fetch_read_en) begin
                r_fetch_pend <= 1'b1;
                r_fetch_addr <= fetch_read_addr;
            end else if (w_grant_fetch) begin
                r_fetch_pend <= 1'b0;
            end

            if (w_data_req) begin
                r_data_pend  <= 1'b1;
                r_data_write <= data_write_en;
                r_data_addr  <= data_addr;
                r_data_wdata <= data_write_en ? data_wdata : '0;
                r_data_be    <= data_write_en ? data_byte_en : 4'hF;
            end else if (w_grant_data) begin
                r_data_pend <= 1'b0;
            end

            if (w_grant_fetch) begin
                r_last_grant_data <= 1'b0;
            end else if (w_grant_data) begin
                r_last_grant_data <= 1'b1;
            end

            r_fetch_done <= w_finish && (r_state == S_FETCH);
            r_data_done  <= w_finish && (r_state == S_DATA);

            // Watchdog completions return zero data instead of the bus value.
            if (w_finish && (r_state == S_FETCH)) begin
                r_fetch_data     <= mem_done ? mem_rdata : '0;
                r_fetch_addr_ack <= mem_done ? mem_addr_ack : '0;
            end
            if (w_finish && (r_state == S_DATA)) begin
                r_data_rdata <= mem_done ? mem_rdata : '0;
            end
        end
    end

    assign fetch_done     = r_fetch_done;
    assign fetch_data     = r_fetch_data;
    assign fetch_addr_ack = r_fetch_addr_ack;
    assign data_done      = r_data_done;
    assign data_rdata     = r_data_rdata;

endmodule

// File: tb/tb_rattlesnake_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rattlesnake_mem_arbiter
//
// Directed stimulus for the fetch/LSU memory arbiter. Inputs change 1 ns after
// each rising edge; outputs are sampled on the falling edge. A transaction
// level model of the arbiter is checked against every output on every cycle,
// and hand-computed literal expectations pin the key cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_rattlesnake_mem_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_reset;
    logic        fetch_read_en;
    logic [31:0] fetch_read_addr;
    logic        fetch_done;
    logic [31:0] fetch_data;
    logic [13:0] fetch_addr_ack;
    logic        data_read_en;
    logic        data_write_en;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byte_en;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [13:0] mem_addr_ack;
    logic        bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rattlesnake_mem_arbiter #(
        .XLEN(32), .PC_BITWIDTH(32), .MEM_ADDR_BITS(14), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .fetch_read_en(fetch_read_en), .fetch_read_addr(fetch_read_addr),
        .fetch_done(fetch_done), .fetch_data(fetch_data), .fetch_addr_ack(fetch_addr_ack),
        .data_read_en(data_read_en), .data_write_en(data_write_en), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byte_en(data_byte_en),
        .data_done(data_done), .data_rdata(data_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_addr_ack(mem_addr_ack),
        .bus_error(bus_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Transaction-level model: pending request records, current owner and
    // the issue time of the outstanding access.
    // -----------------------------------------------------------------------
    bit          m_f_pend;
    logic [31:0] m_f_addr;
    bit          m_d_pend;
    bit          m_d_wr;
    logic [31:0] m_d_addr;
    logic [31:0] m_d_wdata;
    logic [3:0]  m_d_be;
    int          m_owner;        // 0 none, 1 fetch, 2 data
    bit          m_last_data;
    int          m_issue_cyc;
    int          cyc = 0;
    bit          e_fdone, e_ddone, e_berr;
    logic [31:0] e_fdata, e_drdata;
    logic [13:0] e_fack;

    task automatic model_reset();
        m_f_pend = 0; m_f_addr = '0;
        m_d_pend = 0; m_d_wr = 0; m_d_addr = '0; m_d_wdata = '0; m_d_be = '0;
        m_owner = 0; m_last_data = 1; m_issue_cyc = 0;
        e_fdone = 0; e_ddone = 0; e_berr = 0;
        e_fdata = '0; e_drdata = '0; e_fack = '0;
    endtask

    initial model_reset();

    always @(negedge clk) begin : model
        int          issue;
        bit          fin;
        bit          to;
        logic        x_en, x_wr;
        logic [31:0] x_addr, x_wdata;
        logic [3:0]  x_be;
        cyc++;
        issue = 0;
        if (reset_n && !sync_reset && m_owner == 0) begin
            if (m_f_pend && (!m_d_pend || m_last_data)) issue = 1;
            else if (m_d_pend) issue = 2;
        end
        x_en = (issue != 0); x_wr = 0; x_addr = '0; x_wdata = '0; x_be = '0;
        if (issue == 1) begin
            x_addr = m_f_addr; x_be = 4'hF;
        end else if (issue == 2) begin
            x_wr = m_d_wr; x_addr = m_d_addr;
            x_wdata = m_d_wr ? m_d_wdata : 32'h0;
            x_be = m_d_wr ? m_d_be : 4'hF;
        end
        chk("mem_enable", mem_enable, x_en);
        chk("mem_write", mem_write, x_wr);
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wdata);
        chk("mem_byte_en", mem_byte_en, x_be);
        chk("fetch_done", fetch_done, e_fdone);
        chk("fetch_data", fetch_data, e_fdata);
        chk("fetch_addr_ack", fetch_addr_ack, e_fack);
        chk("data_done", data_done, e_ddone);
        chk("data_rdata", data_rdata, e_drdata);
        chk("bus_error", bus_error, e_berr);
        if (issue == 1) $display("issue fetch addr=0x%08h", x_addr);
        if (issue == 2) $display("issue %s addr=0x%08h wdata=0x%08h be=%b",
                                 x_wr ? "store" : "load", x_addr, x_wdata, x_be);

        if (!reset_n || sync_reset) begin
            model_reset();
        end else begin
            e_fdone = 0; e_ddone = 0; e_berr = 0;
            if (m_owner != 0) begin
                fin = 0; to = 0;
                if (mem_done) fin = 1;
`ifdef RATTLESNAKE_MEM_ARB_WATCHDOG_EN
                else if (cyc - m_issue_cyc == TIMEOUT - 1) begin
                    fin = 1; to = 1;
                end
`endif
                if (fin) begin
                    if (m_owner == 1) begin
                        e_fdone = 1;
                        e_fdata = to ? 32'h0 : mem_rdata;
                        e_fack  = to ? 14'h0 : mem_addr_ack;
                    end else begin
                        e_ddone  = 1;
                        e_drdata = to ? 32'h0 : mem_rdata;
                    end
                    e_berr = to;
                    $display("complete %s data=0x%08h%s", m_owner == 1 ? "fetch" : "data",
                             to ? 32'h0 : mem_rdata, to ? " (timeout)" : "");
                    m_owner = 0;
                end
            end
            if (fetch_read_en) begin
                m_f_pend = 1; m_f_addr = fetch_read_addr;
            end else if (issue == 1) begin
                m_f_pend = 0;
            end
            if (data_read_en || data_write_en) begin
                m_d_pend = 1; m_d_wr = data_write_en; m_d_addr = data_addr;
                m_d_wdata = data_wdata; m_d_be = data_byte_en;
            end else if (issue == 2) begin
                m_d_pend = 0;
            end
            if (issue != 0) begin
                m_owner = issue;
                m_issue_cyc = cyc;
                m_last_data = (issue == 2);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        fetch_read_en = 0; data_read_en = 0; data_write_en = 0;
        mem_done = 0; sync_reset = 0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, limit 200000 ns");
        $fatal(1);
    end

    initial begin
        reset_n = 0; sync_reset = 0;
        fetch_read_en = 0; fetch_read_addr = '0;
        data_read_en = 0; data_write_en = 0; data_addr = '0;
        data_wdata = '0; data_byte_en = '0;
        mem_done = 0; mem_rdata = '0; mem_addr_ack = '0;

        // Reset state
        next_cycle(); next_cycle();
        fetch_read_en = 1; fetch_read_addr = 32'h0000_0999;   // ignored in reset
        mid();
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_fetch_done", fetch_done, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_bus_error", bus_error, 0);
        next_cycle();
        reset_n = 1;
        next_cycle();
        mid();
        chk("rst_no_issue", mem_enable, 0);

        // 1: single fetch
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h0000_0100;
        next_cycle(); mid();
        chk("t1_mem_enable", mem_enable, 1);
        chk("t1_mem_write", mem_write, 0);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_byte_en", mem_byte_en, 4'hF);
        next_cycle(); next_cycle();
        next_cycle(); mem_done = 1; mem_rdata = 32'h0000_0013; mem_addr_ack = 14'h040;
        next_cycle(); mid();
        chk("t1_fetch_done", fetch_done, 1);
        chk("t1_fetch_data", fetch_data, 32'h13);
        chk("t1_fetch_ack", fetch_addr_ack, 14'h040);
        chk("t1_data_done", data_done, 0);
        next_cycle(); mid();
        chk("t1_fetch_done_pulse", fetch_done, 0);
        chk("t1_fetch_data_hold", fetch_data, 32'h13);

        // 2: fetch and load together after a sync reset (last_grant = DATA)
        next_cycle(); sync_reset = 1;
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h300;
        data_read_en = 1; data_addr = 32'h2000;
        mid();
        chk("t2_sync_clears_data", fetch_data, 0);
        next_cycle(); mid();
        chk("t2_fetch_first", mem_addr, 32'h300);
        chk("t2_fetch_first_wr", mem_write, 0);
        next_cycle(); mem_done = 1; mem_rdata = 32'h1111_1111; mem_addr_ack = 14'h0C0;
        next_cycle(); mid();
        chk("t2_fetch_done", fetch_done, 1);
        chk("t2_load_issue", mem_enable, 1);
        chk("t2_load_addr", mem_addr, 32'h2000);
        chk("t2_load_be", mem_byte_en, 4'hF);
        next_cycle();
        next_cycle(); mem_done = 1; mem_rdata = 32'h2222_2222; mem_addr_ack = 14'h800;
        next_cycle(); mid();
        chk("t2_data_done", data_done, 1);
        chk("t2_data_rdata", data_rdata, 32'h2222_2222);
        chk("t2_no_fetch_done", fetch_done, 0);
        chk("t2_fetch_hold", fetch_data, 32'h1111_1111);

        // 3: store with partial byte enables
        next_cycle(); data_write_en = 1; data_addr = 32'h40;
        data_wdata = 32'hDEAD_BEEF; data_byte_en = 4'b0011;
        next_cycle(); mid();
        chk("t3_mem_write", mem_write, 1);
        chk("t3_mem_addr", mem_addr, 32'h40);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_be", mem_byte_en, 4'b0011);
        next_cycle(); mem_done = 1;
        next_cycle(); mid();
        chk("t3_data_done", data_done, 1);

        // 3b: read and write strobes together are a write
        next_cycle(); data_read_en = 1; data_write_en = 1; data_addr = 32'h44;
        data_wdata = 32'h1234_5678; data_byte_en = 4'b1100;
        next_cycle(); mid();
        chk("t3b_is_write", mem_write, 1);
        chk("t3b_be", mem_byte_en, 4'b1100);
        next_cycle(); mem_done = 1;
        next_cycle();

        // 4: two fetch pulses while a load is in flight -> only the second issues
        next_cycle(); data_read_en = 1; data_addr = 32'h80;
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h10;
        mid();
        chk("t4_load_addr", mem_addr, 32'h80);
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h20;
        next_cycle(); mem_done = 1; mem_rdata = 32'h3333_3333;
        next_cycle(); mid();
        chk("t4_data_done", data_done, 1);
        chk("t4_fetch_addr", mem_addr, 32'h20);
        next_cycle(); mem_done = 1; mem_rdata = 32'h4444_4444; mem_addr_ack = 14'h008;
        next_cycle(); mid();
        chk("t4_fetch_data", fetch_data, 32'h4444_4444);
        chk("t4_no_reissue", mem_enable, 0);

        // 4b: fetch pulse during its own grant cycle stays pending
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h50;
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h54;
        mid();
        chk("t4b_first", mem_addr, 32'h50);
        next_cycle(); mem_done = 1; mem_rdata = 32'h5050_5050;
        next_cycle(); mid();
        chk("t4b_second", mem_addr, 32'h54);
        next_cycle(); mem_done = 1; mem_rdata = 32'h5454_5454;
        next_cycle();

        // 5: sync reset abandons an in-flight fetch
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h200;
        next_cycle(); mid();
        chk("t5_issue", mem_enable, 1);
        next_cycle(); sync_reset = 1;
        next_cycle(); mem_done = 1; mem_rdata = 32'h5555_5555;
        next_cycle(); mid();
        chk("t5_no_fetch_done", fetch_done, 0);
        chk("t5_fetch_data_zero", fetch_data, 0);
        chk("t5_data_rdata_zero", data_rdata, 0);
        chk("t5_idle", mem_enable, 0);

        // 6: load that never completes, with a fetch queued behind it
        next_cycle(); data_read_en = 1; data_addr = 32'h104;
        next_cycle();
        next_cycle(); mem_done = 1; mem_rdata = 32'h6666_6666;
        next_cycle(); mid();
        chk("t6_pre_rdata", data_rdata, 32'h6666_6666);
        next_cycle(); data_read_en = 1; data_addr = 32'h400;
        next_cycle(); fetch_read_en = 1; fetch_read_addr = 32'h600;
        mid();
        chk("t6_load_issue", mem_addr, 32'h400);
`ifdef RATTLESNAKE_MEM_ARB_WATCHDOG_EN
        repeat (TIMEOUT - 1) next_cycle();
        mid();
        chk("t6_before_expiry", bus_error, 0);
        next_cycle(); mid();
        chk("t6_bus_error", bus_error, 1);
        chk("t6_data_done", data_done, 1);
        chk("t6_rdata_zero", data_rdata, 0);
        chk("t6_next_issue", mem_addr, 32'h600);
`else
        repeat (20) next_cycle();
        mid();
        chk("t6_still_waiting", data_done, 0);
        chk("t6_no_bus_error", bus_error, 0);
        chk("t6_no_issue", mem_enable, 0);
        next_cycle(); mem_done = 1; mem_rdata = 32'h7070_7070;
        next_cycle(); mid();
        chk("t6_late_done", data_done, 1);
        chk("t6_next_issue", mem_addr, 32'h600);
`endif
        next_cycle(); mem_done = 1; mem_rdata = 32'h7777_7777; mem_addr_ack = 14'h180;
        next_cycle(); mid();
        chk("t6_fetch_done", fetch_done, 1);
        chk("t6_fetch_data", fetch_data, 32'h7777_7777);

        // mem_done while idle is ignored
        next_cycle(); mem_done = 1; mem_rdata = 32'h9999_9999;
        next_cycle(); mid();
        chk("idle_done_ignored", fetch_done | data_done, 0);

        next_cycle(); next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
